arb_grant_ctrl: RTL and testbench
=================================

ARB_GRANT_CTRL -- requirements
Module: arb_grant_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the payload width per requester.
REQ-002 The block SHALL have parameter XFER_LEN, default 4, the beats served per grant (legal range 1..16).
REQ-003 The block SHALL have parameter TIMEOUT, default 15, the consecutive stalled XFER cycles before the grant is abandoned (legal range 1..255).
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 grant  input  4  one-hot grant from the round-robin arbiter.
REQ-008 src_data  input  4*DATA_W  requester payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 src_valid  input  4  per-requester data valid.
REQ-010 src_ready  output  4  per-requester ready; at most one bit is high.
REQ-011 out_data  output  DATA_W  payload of the current owner.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 ack  output  1  one-cycle pulse that releases the grant and advances the arbiter's ring counter.
REQ-015 owner  output  2  index of the latched owner.
REQ-016 busy  output  1  high in XFER and ACK.
REQ-017 grant_err  output  1  one-cycle pulse when grant has more than one bit set while in IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, XFER and ACK.
REQ-019 IDLE, grant exactly one-hot: at the next edge the block SHALL latch the grant index into owner, clear beat_cnt and stall_cnt, and enter XFER.
REQ-020 IDLE, grant zero: the block SHALL stay in IDLE.
REQ-021 IDLE, grant with 2 or more bits set: the block SHALL pulse grant_err for 1 cycle at the next edge, stay in IDLE and leave owner unchanged.
REQ-022 XFER: the block SHALL drive combinationally out_valid=src_valid[owner], out_data=src_data[owner slice], src_ready[owner]=out_ready, and all other src_ready bits to 0.
REQ-023 A beat is defined as out_valid and out_ready both high at a rising edge; each beat SHALL increment beat_cnt by 1 and clear stall_cnt.
REQ-024 XFER, beat while beat_cnt==XFER_LEN-1: the block SHALL enter ACK.
REQ-025 XFER, no beat: stall_cnt SHALL increment by 1; when stall_cnt==TIMEOUT-1 and no beat occurs, the block SHALL enter ACK (abandon).
REQ-026 When a beat and the timeout occur in the same cycle, the beat SHALL win: it is counted, and stall_cnt clears.
REQ-027 Changes on grant during XFER or ACK SHALL be ignored, because owner is latched.
REQ-028 ACK: ack=1 for exactly one cycle, then IDLE unconditionally; out_valid=0 and src_ready=0 while in ACK.
REQ-029 The ACK-to-IDLE-to-XFER sequence SHALL give at least 2 cycles between consecutive grants, so the arbiter's updated grant is sampled in IDLE.
REQ-030 Outside XFER, out_valid and src_ready SHALL be 0 and out_data SHALL be 0.
REQ-031 beat_cnt SHALL be sized $clog2(XFER_LEN)+1 bits and stall_cnt 8 bits; neither SHALL wrap, because each is cleared on entry to XFER.
REQ-032 busy SHALL be registered-state decoded: 1 in XFER and ACK, 0 in IDLE.

Reset
REQ-033 Reset high at a rising edge SHALL force IDLE, owner=0, beat_cnt=0 and stall_cnt=0, and SHALL leave ack, grant_err, busy, out_valid, src_ready and out_data at 0 in the following cycle.
REQ-034 Reset mid-XFER SHALL abandon the transfer without an ack pulse.
REQ-035 Reset SHALL take priority over every other transition.

Verification
REQ-036 grant=4'b0100, src_valid[2]=1 and out_ready=1 held: -> XFER next cycle, owner=2, 4 beats on consecutive cycles, ack pulses for 1 cycle, then IDLE.
REQ-037 grant=4'b0001, out_ready=0 throughout: -> after 15 XFER cycles the block enters ACK, ack=1 once, and out_valid is never accepted.
REQ-038 grant=4'b0011 in IDLE: -> grant_err=1 for 1 cycle, state stays IDLE, ack=0.
REQ-039 grant changes from 4'b0010 to 4'b1000 mid-XFER: -> owner stays 1, src_ready[3]=0, and the transfer completes normally.
REQ-040 Reset asserted after 2 of 4 beats: -> next cycle IDLE, all outputs 0, no ack pulse.
REQ-041 Beat occurring on the cycle stall_cnt==14: -> the beat is counted, stall_cnt clears, and no early ACK occurs.

Source files
------------

// File: rtl/arb_grant_ctrl.sv
// Grant controller: latches one arbiter grant, serves XFER_LEN beats
// from the owning requester, then pulses ack to release the grant.
module arb_grant_ctrl #(
    parameter int DATA_W   = 8,
    parameter int XFER_LEN = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          grant,
    input  logic [4*DATA_W-1:0] src_data,
    input  logic [3:0]          src_valid,
    output logic [3:0]          src_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                ack,
    output logic [1:0]          owner,
    output logic                busy,
    output logic                grant_err
);

    localparam int BW = $clog2(XFER_LEN) + 1;
    localparam logic [BW-1:0] BEAT_LAST  = BW'(XFER_LEN - 1);
    localparam logic [7:0]    STALL_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        ACK
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [BW-1:0]   beat_q,  beat_d;
    logic [7:0]      stall_q, stall_d;
    logic            gerr_q,  gerr_d;

    logic            beat;
    logic            grant_one;
    logic            grant_multi;
    logic [1:0]      grant_idx;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) grant_idx = 2'(i);
        end
        grant_one   = (grant != 4'd0) && ((grant & (grant - 4'd1)) == 4'd0);
        grant_multi = (grant != 4'd0) && !grant_one;
    end

    // Datapath is only connected while a transfer owns the bus.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        src_ready = 4'd0;
        if (state_q == XFER) begin
            out_valid          = src_valid[owner_q];
            out_data           = src_data[DATA_W*int'(owner_q) +: DATA_W];
            src_ready[owner_q] = out_ready;
        end
    end

    assign beat      = out_valid & out_ready;
    assign ack       = (state_q == ACK);
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign grant_err = gerr_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beat_d  = beat_q;
        stall_d = stall_q;
        gerr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_one) begin
                    owner_d = grant_idx;
                    beat_d  = '0;
                    stall_d = '0;
                    state_d = XFER;
                end else if (grant_multi) begin
                    gerr_d = 1'b1;
                end
            end
            XFER: begin
                // A beat beats the timeout when both land together.
                if (beat) begin
                    beat_d  = beat_q + 1'b1;
                    stall_d = '0;
                    if (beat_q == BEAT_LAST) state_d = ACK;
                end else begin
                    stall_d = stall_q + 1'b1;
                    if (stall_q == STALL_LAST) state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            beat_q  <= '0;
            stall_q <= '0;
            gerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beat_q  <= beat_d;
            stall_q <= stall_d;
            gerr_q  <= gerr_d;
        end
    end

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// Bench for arb_grant_ctrl: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_arb_grant_ctrl;

    localparam int DW = 8;
    localparam int XL = 4;
    localparam int TO = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    grant;
    logic [4*DW-1:0] src_data;
    logic [3:0]    src_valid;
    logic [3:0]    src_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          ack;
    logic [1:0]    owner;
    logic          busy;
    logic          grant_err;

    always #5 clock = ~clock;

    arb_grant_ctrl #(
        .DATA_W  (DW),
        .XFER_LEN(XL),
        .TIMEOUT (TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .grant    (grant),
        .src_data (src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ack      (ack),
        .owner    (owner),
        .busy     (busy),
        .grant_err(grant_err)
    );

    int n_chk;
    int n_fail;
    int dut_acks;

    // Reference: phase 0 idle, 1 transferring, 2 releasing.
    int m_phase;
    int m_owner;
    int m_rem;
    int m_budget;
    bit m_gerr;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_owner  = 0;
        m_rem    = 0;
        m_budget = 0;
        m_gerr   = 1'b0;
    endtask

    task automatic cyc(input bit r, input logic [3:0] g,
                       input logic [3:0] sv, input bit ordy);
        bit         xf;
        logic [3:0] e_rdy;
        bit         e_vld;
        bit         hs;
        int         ones;
        @(negedge clock);
        reset     = r;
        grant     = g;
        src_valid = sv;
        out_ready = ordy;
        src_data  = $urandom;
        #1;
        xf    = (m_phase == 1);
        e_vld = xf && sv[m_owner];
        e_rdy = (xf && ordy) ? (4'd1 << m_owner) : 4'd0;
        chk("out_valid", 32'(out_valid), 32'(e_vld));
        chk("out_data", 32'(out_data),
            xf ? 32'(src_data[m_owner*DW +: DW]) : 32'd0);
        chk("src_ready", 32'(src_ready), 32'(e_rdy));
        chk("ack", 32'(ack), 32'(m_phase == 2));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("grant_err", 32'(grant_err), 32'(m_gerr));
        if (ack) dut_acks++;
        hs = e_vld && ordy;
        if (r) begin
            model_reset();
        end else begin
            m_gerr = 1'b0;
            case (m_phase)
                0: begin
                    ones = $countones(g);
                    if (ones == 1) begin
                        for (int i = 0; i < 4; i++)
                            if (g[i]) m_owner = i;
                        m_rem    = XL;
                        m_budget = TO;
                        m_phase  = 1;
                    end else if (ones > 1) begin
                        m_gerr = 1'b1;
                    end
                end
                1: begin
                    if (hs) begin
                        m_rem--;
                        m_budget = TO;
                        if (m_rem == 0) m_phase = 2;
                    end else begin
                        m_budget--;
                        if (m_budget == 0) m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    initial begin
        logic [3:0] g;
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        grant     = 4'd0;
        src_valid = 4'd0;
        src_data  = '0;
        out_ready = 1'b0;
        @(posedge clock);
        model_reset();

        // reset state
        cyc(1, 4'b0000, 4'b0000, 0);
        cyc(0, 4'b0000, 4'b1111, 1);

        // owner 2, four back-to-back beats
        dut_acks = 0;
        for (int i = 0; i < 6; i++) cyc(0, 4'b0100, 4'b0100, 1);
        cyc(0, 4'b0000, 4'b0100, 1);
        cyc(0, 4'b0000, 4'b0100, 1);
        chk("r036_acks", 32'(dut_acks), 32'd1);

        // timeout abandon with downstream stalled
        dut_acks = 0;
        cyc(0, 4'b0001, 4'b0001, 0);
        for (int i = 0; i < 16; i++) cyc(0, 4'b0000, 4'b0001, 0);
        chk("r037_acks", 32'(dut_acks), 32'd1);
        cyc(0, 4'b0000, 4'b0001, 0);
        chk("r037_idle", 32'(busy), 32'd0);

        // multi-bit grant
        dut_acks = 0;
        cyc(0, 4'b0011, 4'b1111, 1);
        cyc(0, 4'b0000, 4'b1111, 1);
        chk("r038_gerr", 32'(grant_err), 32'd1);
        chk("r038_busy", 32'(busy), 32'd0);
        cyc(0, 4'b0000, 4'b1111, 1);
        chk("r038_acks", 32'(dut_acks), 32'd0);

        // grant moves mid-transfer
        dut_acks = 0;
        cyc(0, 4'b0010, 4'b1111, 1);
        for (int i = 0; i < 5; i++) cyc(0, 4'b1000, 4'b1111, 1);
        chk("r039_acks", 32'(dut_acks), 32'd1);
        cyc(0, 4'b0000, 4'b1111, 1);

        // reset after two beats
        dut_acks = 0;
        cyc(0, 4'b0001, 4'b0001, 1);
        cyc(0, 4'b0000, 4'b0001, 1);
        cyc(0, 4'b0000, 4'b0001, 1);
        cyc(1, 4'b0000, 4'b0001, 1);
        cyc(0, 4'b0000, 4'b0001, 1);
        chk("r040_acks", 32'(dut_acks), 32'd0);
        chk("r040_busy", 32'(busy), 32'd0);

        // beat on the last stall cycle must not end the grant
        dut_acks = 0;
        cyc(0, 4'b0100, 4'b0100, 0);
        for (int i = 0; i < 14; i++) cyc(0, 4'b0000, 4'b0100, 0);
        cyc(0, 4'b0000, 4'b0100, 1);
        for (int i = 0; i < 14; i++) cyc(0, 4'b0000, 4'b0100, 0);
        chk("r041_no_early", 32'(dut_acks), 32'd0);
        cyc(0, 4'b0000, 4'b0100, 0);
        cyc(0, 4'b0000, 4'b0100, 0);
        chk("r041_acks", 32'(dut_acks), 32'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom % 4)
                0:       g = 4'd0;
                3:       g = 4'($urandom);
                default: g = 4'd1 << ($urandom % 4);
            endcase
            cyc(($urandom % 60) == 0, g, 4'($urandom),
                ($urandom % 4) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
